// File: rtl/passcode_lock.sv
`default_nettype none
// ============================================================================
// Module   : passcode_lock
// Brief    : Keypad passcode lock with failure lockout, idle timeout and
//            in-field passcode reprogramming.
// Revision : 1.0 - initial release
// ============================================================================
module passcode_lock #(
    parameter int                          KEY_W        = 4,
    parameter int                          CODE_LEN     = 4,
    parameter int                          MAX_FAIL     = 3,
    parameter int                          LOCK_CYCLES  = 16,
    parameter int                          TIMEOUT      = 12,
    parameter logic [CODE_LEN*KEY_W-1:0]   DEFAULT_CODE = {CODE_LEN{KEY_W'(5)}}
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            key_valid,
    input  logic [KEY_W-1:0]                key,
    input  logic                            lock_req,
    input  logic                            prog_req,
    output logic                            unlock,
    output logic                            err_pulse,
    output logic                            buzz,
    output logic                            locked_out,
    output logic                            prog_done,
    output logic [$clog2(CODE_LEN+1)-1:0]   digit_cnt,
    output logic [$clog2(MAX_FAIL+1)-1:0]   fail_cnt
);

    localparam int c_DIG_W  = $clog2(CODE_LEN + 1);
    localparam int c_FAIL_W = $clog2(MAX_FAIL + 1);
    localparam int c_IDLE_W = $clog2(TIMEOUT + 1);
    localparam int c_LOCK_W = $clog2(LOCK_CYCLES + 1);

    localparam logic [c_DIG_W-1:0]  c_LAST_DIGIT = c_DIG_W'(CODE_LEN - 1);
    localparam logic [c_FAIL_W-1:0] c_FAIL_MAX   = c_FAIL_W'(MAX_FAIL);
    localparam logic [c_FAIL_W-1:0] c_FAIL_LAST  = c_FAIL_W'(MAX_FAIL - 1);
    localparam logic [c_IDLE_W-1:0] c_IDLE_LAST  = c_IDLE_W'(TIMEOUT - 1);
    localparam logic [c_LOCK_W-1:0] c_LOCK_LAST  = c_LOCK_W'(LOCK_CYCLES - 1);

    typedef enum logic [1:0] {
        S_ENTRY    = 2'd0,
        S_UNLOCKED = 2'd1,
        S_PROGRAM  = 2'd2,
        S_LOCKOUT  = 2'd3
    } state_t;

    state_t                      r_state,     w_state_nxt;
    logic [c_DIG_W-1:0]          r_digit_cnt, w_digit_nxt;
    logic [c_FAIL_W-1:0]         r_fail_cnt,  w_fail_nxt;
    logic [c_IDLE_W-1:0]         r_idle,      w_idle_nxt;
    logic [c_LOCK_W-1:0]         r_lock_cnt,  w_lock_nxt;
    logic                        r_mismatch,  w_mis_nxt;
    logic [CODE_LEN*KEY_W-1:0]   r_code,      w_code_nxt;
    logic [CODE_LEN*KEY_W-1:0]   r_shadow,    w_shadow_nxt;
    logic [CODE_LEN*KEY_W-1:0]   w_shadow_wr;
    logic                        w_err_nxt;
    logic                        w_done_nxt;
    logic                        r_unlock;
    logic                        r_err;
    logic                        r_lockout;
    logic                        r_done;
    int                          w_pos;
    logic                        w_digit_bad;
    logic                        w_last;
    logic                        w_timeout;

    assign w_pos       = int'(r_digit_cnt) * KEY_W;
    assign w_digit_bad = (key != r_code[w_pos +: KEY_W]);
    assign w_last      = (r_digit_cnt == c_LAST_DIGIT);
    // Timeout only fires on a cycle with no key; a coincident key wins.
    assign w_timeout   = !key_valid && (r_digit_cnt != '0) && (r_idle == c_IDLE_LAST);

    always_comb begin
        w_shadow_wr             = r_shadow;
        w_shadow_wr[w_pos +: KEY_W] = key;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_digit_nxt  = r_digit_cnt;
        w_fail_nxt   = r_fail_cnt;
        w_idle_nxt   = r_idle;
        w_lock_nxt   = r_lock_cnt;
        w_mis_nxt    = r_mismatch;
        w_code_nxt   = r_code;
        w_shadow_nxt = r_shadow;
        w_err_nxt    = 1'b0;
        w_done_nxt   = 1'b0;

        case (r_state)
            S_ENTRY: begin
                if (key_valid) begin
                    w_idle_nxt = '0;
                    if (w_last) begin
                        w_digit_nxt = '0;
                        w_mis_nxt   = 1'b0;
                        if (r_mismatch || w_digit_bad) begin
                            w_err_nxt = 1'b1;
                            if (r_fail_cnt >= c_FAIL_LAST) begin
                                w_fail_nxt  = c_FAIL_MAX;
                                w_lock_nxt  = '0;
                                w_state_nxt = S_LOCKOUT;
                            end else begin
                                w_fail_nxt = r_fail_cnt + c_FAIL_W'(1);
                            end
                        end else begin
                            w_fail_nxt  = '0;
                            w_state_nxt = S_UNLOCKED;
                        end
                    end else begin
                        w_digit_nxt = r_digit_cnt + c_DIG_W'(1);
                        w_mis_nxt   = r_mismatch | w_digit_bad;
                    end
                end else if (w_timeout) begin
                    w_digit_nxt = '0;
                    w_mis_nxt   = 1'b0;
                    w_idle_nxt  = '0;
                end else if (r_digit_cnt != '0) begin
                    w_idle_nxt = r_idle + c_IDLE_W'(1);
                end
            end

            S_UNLOCKED: begin
                if (lock_req) begin
                    w_state_nxt = S_ENTRY;
                end else if (prog_req) begin
                    w_state_nxt = S_PROGRAM;
                    w_digit_nxt = '0;
                    w_idle_nxt  = '0;
                end
            end

            S_PROGRAM: begin
                if (key_valid) begin
                    w_idle_nxt   = '0;
                    w_shadow_nxt = w_shadow_wr;
                    if (w_last) begin
                        w_code_nxt  = w_shadow_wr;
                        w_done_nxt  = 1'b1;
                        w_digit_nxt = '0;
                        w_state_nxt = S_UNLOCKED;
                    end else begin
                        w_digit_nxt = r_digit_cnt + c_DIG_W'(1);
                    end
                end else if (w_timeout) begin
                    w_digit_nxt = '0;
                    w_idle_nxt  = '0;
                    w_state_nxt = S_UNLOCKED;
                end else if (r_digit_cnt != '0) begin
                    w_idle_nxt = r_idle + c_IDLE_W'(1);
                end
            end

            S_LOCKOUT: begin
                if (r_lock_cnt == c_LOCK_LAST) begin
                    w_lock_nxt  = '0;
                    w_fail_nxt  = '0;
                    w_digit_nxt = '0;
                    w_state_nxt = S_ENTRY;
                end else begin
                    w_lock_nxt = r_lock_cnt + c_LOCK_W'(1);
                end
            end

            default: w_state_nxt = S_ENTRY;
        endcase
    end

    // Status outputs are registered from the next state so they align with it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_ENTRY;
            r_digit_cnt <= '0;
            r_fail_cnt  <= '0;
            r_idle      <= '0;
            r_lock_cnt  <= '0;
            r_mismatch  <= 1'b0;
            r_code      <= DEFAULT_CODE;
            r_shadow    <= '0;
            r_unlock    <= 1'b0;
            r_err       <= 1'b0;
            r_lockout   <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_digit_cnt <= w_digit_nxt;
            r_fail_cnt  <= w_fail_nxt;
            r_idle      <= w_idle_nxt;
            r_lock_cnt  <= w_lock_nxt;
            r_mismatch  <= w_mis_nxt;
            r_code      <= w_code_nxt;
            r_shadow    <= w_shadow_nxt;
            r_unlock    <= (w_state_nxt == S_UNLOCKED) || (w_state_nxt == S_PROGRAM);
            r_err       <= w_err_nxt;
            r_lockout   <= (w_state_nxt == S_LOCKOUT);
            r_done      <= w_done_nxt;
        end
    end

    assign unlock     = r_unlock;
    assign err_pulse  = r_err;
    assign buzz       = r_lockout;
    assign locked_out = r_lockout;
    assign prog_done  = r_done;
    assign digit_cnt  = r_digit_cnt;
    assign fail_cnt   = r_fail_cnt;

endmodule
`default_nettype wire

// File: tb/tb_passcode_lock.sv
`default_nettype none
// ============================================================================
// Module   : tb_passcode_lock
// Brief    : Scenario tasks plus randomized run against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_passcode_lock;

    localparam int CODE_LEN    = 4;
    localparam int MAX_FAIL    = 3;
    localparam int LOCK_CYCLES = 16;
    localparam int TIMEOUT     = 12;

    localparam int M_ENTRY = 0;
    localparam int M_OPEN  = 1;
    localparam int M_PROG  = 2;
    localparam int M_LOCK  = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       key_valid = 1'b0;
    logic [3:0] key = 4'd0;
    logic       lock_req = 1'b0;
    logic       prog_req = 1'b0;
    logic       unlock, err_pulse, buzz, locked_out, prog_done;
    logic [2:0] digit_cnt;
    logic [1:0] fail_cnt;

    int n_vec = 0;
    int n_err = 0;

    int m_mode, m_fail, m_idle, m_lock_left;
    int m_code[CODE_LEN];
    int m_ent[$];
    bit m_err, m_done;

    always #5 clk = ~clk;

    passcode_lock dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_valid  (key_valid),
        .key        (key),
        .lock_req   (lock_req),
        .prog_req   (prog_req),
        .unlock     (unlock),
        .err_pulse  (err_pulse),
        .buzz       (buzz),
        .locked_out (locked_out),
        .prog_done  (prog_done),
        .digit_cnt  (digit_cnt),
        .fail_cnt   (fail_cnt)
    );

    function automatic bit ent_matches();
        for (int i = 0; i < CODE_LEN; i++)
            if (m_ent[i] != m_code[i]) return 1'b0;
        return 1'b1;
    endfunction

    // Reference: the entry is kept as a list of digits and judged as a whole.
    task automatic model_edge(input bit rn, input bit kv, input int k, input bit lr, input bit pr);
        m_err  = 1'b0;
        m_done = 1'b0;
        if (!rn) begin
            m_mode = M_ENTRY; m_fail = 0; m_idle = 0; m_lock_left = 0;
            m_ent.delete();
            for (int i = 0; i < CODE_LEN; i++) m_code[i] = 5;
        end else begin
            case (m_mode)
                M_ENTRY, M_PROG: begin
                    if (kv) begin
                        m_ent.push_back(k);
                        m_idle = 0;
                        if (m_ent.size() == CODE_LEN) begin
                            if (m_mode == M_PROG) begin
                                for (int i = 0; i < CODE_LEN; i++) m_code[i] = m_ent[i];
                                m_done = 1'b1;
                                m_mode = M_OPEN;
                            end else if (ent_matches()) begin
                                m_mode = M_OPEN;
                                m_fail = 0;
                            end else begin
                                m_err = 1'b1;
                                m_fail++;
                                if (m_fail >= MAX_FAIL) begin
                                    m_fail = MAX_FAIL;
                                    m_mode = M_LOCK;
                                    m_lock_left = LOCK_CYCLES;
                                end
                            end
                            m_ent.delete();
                        end
                    end else if (m_ent.size() > 0) begin
                        m_idle++;
                        if (m_idle == TIMEOUT) begin
                            m_ent.delete();
                            m_idle = 0;
                            if (m_mode == M_PROG) m_mode = M_OPEN;
                        end
                    end
                end
                M_OPEN: begin
                    if (lr) m_mode = M_ENTRY;
                    else if (pr) begin
                        m_mode = M_PROG;
                        m_ent.delete();
                    end
                end
                default: begin
                    m_lock_left--;
                    if (m_lock_left == 0) begin
                        m_mode = M_ENTRY;
                        m_fail = 0;
                    end
                end
            endcase
        end
    endtask

    task automatic step(input bit kv, input int k, input bit lr = 1'b0,
                        input bit pr = 1'b0, input bit rn = 1'b1);
        rst_n = rn; key_valid = kv; key = 4'(k); lock_req = lr; prog_req = pr;
        @(posedge clk);
        model_edge(rn, kv, k, lr, pr);
        #1;
        rst_n = 1'b1; key_valid = 1'b0; lock_req = 1'b0; prog_req = 1'b0;
        key = 4'($urandom_range(0, 15));
    endtask

    task automatic enter4(input int a, input int b, input int c, input int d);
        step(1'b1, a); step(1'b1, b); step(1'b1, c); step(1'b1, d);
    endtask

    task automatic test_reset();
        step(1'b0, 0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 0, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if ({unlock, err_pulse, buzz, locked_out, prog_done} !== 5'b0) begin
            n_err++; $display("FAIL reset_flags got=%b want=00000", {unlock, err_pulse, buzz, locked_out, prog_done});
        end
        n_vec++;
        if (digit_cnt !== 3'd0) begin n_err++; $display("FAIL reset_digit got=%0d want=0", digit_cnt); end
        n_vec++;
        if (fail_cnt !== 2'd0) begin n_err++; $display("FAIL reset_fail got=%0d want=0", fail_cnt); end
    endtask

    task automatic test_unlock();
        step(1'b1, 5); step(1'b1, 5); step(1'b1, 5);
        n_vec++;
        if (unlock !== 1'b0 || digit_cnt !== 3'd3) begin
            n_err++; $display("FAIL partial_entry unlock=%b digit=%0d want 0/3", unlock, digit_cnt);
        end
        step(1'b1, 5);
        n_vec++;
        if (unlock !== 1'b1 || fail_cnt !== 2'd0 || digit_cnt !== 3'd0) begin
            n_err++; $display("FAIL unlock_5555 unlock=%b fail=%0d digit=%0d want 1/0/0", unlock, fail_cnt, digit_cnt);
        end
        step(1'b0, 0, 1'b1);
        n_vec++;
        if (unlock !== 1'b0) begin n_err++; $display("FAIL relock got=%b want=0", unlock); end
    endtask

    task automatic test_lockout();
        int cnt;
        for (int r = 0; r < 3; r++) begin
            enter4(5, 3, 5, 5);
            n_vec++;
            if (err_pulse !== 1'b1 || fail_cnt !== 2'(r + 1)) begin
                n_err++; $display("FAIL wrong_code_%0d err=%b fail=%0d want 1/%0d", r, err_pulse, fail_cnt, r + 1);
            end
            if (r < 2) begin
                step(1'b0, 0);
                n_vec++;
                if (err_pulse !== 1'b0 || buzz !== 1'b0) begin
                    n_err++; $display("FAIL err_width_%0d err=%b buzz=%b want 0/0", r, err_pulse, buzz);
                end
            end
        end
        cnt = 0;
        for (int i = 0; i < 24; i++) begin
            n_vec++;
            if (buzz !== locked_out || buzz !== (m_mode == M_LOCK)) begin
                n_err++; $display("FAIL lockout_cycle_%0d buzz=%b locked_out=%b want %b", i, buzz, locked_out, m_mode == M_LOCK);
            end
            if (buzz === 1'b1) cnt++;
            if (i == 1) begin
                n_vec++;
                if (err_pulse !== 1'b0) begin n_err++; $display("FAIL lockout_err got=%b want=0", err_pulse); end
            end
            step(m_mode == M_LOCK, $urandom_range(0, 15));
        end
        n_vec++;
        if (cnt != LOCK_CYCLES) begin n_err++; $display("FAIL lockout_len got=%0d want=%0d", cnt, LOCK_CYCLES); end
        n_vec++;
        if (fail_cnt !== 2'd0 || digit_cnt !== 3'd0) begin
            n_err++; $display("FAIL lockout_exit fail=%0d digit=%0d want 0/0", fail_cnt, digit_cnt);
        end
    endtask

    task automatic test_timeout();
        bit saw_err;
        saw_err = 1'b0;
        step(1'b1, 5); step(1'b1, 5);
        repeat (TIMEOUT - 1) begin step(1'b0, 0); saw_err |= err_pulse; end
        n_vec++;
        if (digit_cnt !== 3'd2) begin n_err++; $display("FAIL pre_timeout digit=%0d want=2", digit_cnt); end
        step(1'b0, 0); saw_err |= err_pulse;
        n_vec++;
        if (digit_cnt !== 3'd0 || saw_err || fail_cnt !== 2'd0) begin
            n_err++; $display("FAIL timeout digit=%0d err=%b fail=%0d want 0/0/0", digit_cnt, saw_err, fail_cnt);
        end
        step(1'b1, 5);
        repeat (TIMEOUT - 1) step(1'b0, 0);
        step(1'b1, 5);
        n_vec++;
        if (digit_cnt !== 3'd2) begin n_err++; $display("FAIL key_on_timeout digit=%0d want=2", digit_cnt); end
        repeat (TIMEOUT) step(1'b0, 0);
        enter4(5, 5, 5, 5);
        n_vec++;
        if (unlock !== 1'b1) begin n_err++; $display("FAIL unlock_after_timeout got=%b want=1", unlock); end
        step(1'b0, 0, 1'b1);
    endtask

    task automatic test_program();
        enter4(5, 5, 5, 5);
        step(1'b0, 0, 1'b0, 1'b1);
        step(1'b1, 1); step(1'b1, 2); step(1'b1, 3);
        n_vec++;
        if (unlock !== 1'b1 || prog_done !== 1'b0) begin
            n_err++; $display("FAIL in_program unlock=%b done=%b want 1/0", unlock, prog_done);
        end
        step(1'b1, 4);
        n_vec++;
        if (prog_done !== 1'b1 || unlock !== 1'b1) begin
            n_err++; $display("FAIL prog_commit done=%b unlock=%b want 1/1", prog_done, unlock);
        end
        step(1'b0, 0);
        n_vec++;
        if (prog_done !== 1'b0) begin n_err++; $display("FAIL prog_done_width got=%b want=0", prog_done); end
        step(1'b0, 0, 1'b1);
        enter4(5, 5, 5, 5);
        n_vec++;
        if (err_pulse !== 1'b1 || unlock !== 1'b0 || fail_cnt !== 2'd1) begin
            n_err++; $display("FAIL old_code_rejected err=%b unlock=%b fail=%0d want 1/0/1", err_pulse, unlock, fail_cnt);
        end
        enter4(1, 2, 3, 4);
        n_vec++;
        if (unlock !== 1'b1 || fail_cnt !== 2'd0) begin
            n_err++; $display("FAIL new_code_unlocks unlock=%b fail=%0d want 1/0", unlock, fail_cnt);
        end
    endtask

    task automatic test_back_to_back_req();
        bit saw_done;
        saw_done = 1'b0;
        step(1'b0, 0, 1'b1, 1'b1);
        step(1'b0, 0);
        n_vec++;
        if (unlock !== 1'b0) begin n_err++; $display("FAIL lock_beats_prog got=%b want=0", unlock); end
        enter4(1, 2, 3, 4);
        step(1'b0, 0, 1'b0, 1'b1);
        step(1'b1, 7); step(1'b1, 8);
        repeat (TIMEOUT) begin step(1'b0, 0); saw_done |= prog_done; end
        n_vec++;
        if (unlock !== 1'b1 || digit_cnt !== 3'd0 || saw_done) begin
            n_err++; $display("FAIL prog_abort unlock=%b digit=%0d done=%b want 1/0/0", unlock, digit_cnt, saw_done);
        end
        step(1'b0, 0, 1'b1);
        enter4(1, 2, 3, 4);
        n_vec++;
        if (unlock !== 1'b1) begin n_err++; $display("FAIL code_kept_after_abort got=%b want=1", unlock); end
        step(1'b0, 0, 1'b1);
    endtask

    task automatic test_reset_mid();
        repeat (3) enter4(5, 3, 5, 5);
        repeat (5) step(1'b0, 0);
        n_vec++;
        if (buzz !== 1'b1) begin n_err++; $display("FAIL mid_lockout buzz=%b want=1", buzz); end
        step(1'b0, 0, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if ({unlock, err_pulse, buzz, locked_out, prog_done, digit_cnt, fail_cnt} !== 10'b0) begin
            n_err++; $display("FAIL reset_in_lockout got=%b want=0", {unlock, err_pulse, buzz, locked_out, prog_done, digit_cnt, fail_cnt});
        end
        enter4(5, 5, 5, 5);
        step(1'b0, 0, 1'b0, 1'b1);
        enter4(9, 9, 9, 9);
        step(1'b0, 0, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if ({unlock, err_pulse, buzz, locked_out, prog_done, digit_cnt, fail_cnt} !== 10'b0) begin
            n_err++; $display("FAIL reset_after_prog got=%b want=0", {unlock, err_pulse, buzz, locked_out, prog_done, digit_cnt, fail_cnt});
        end
        enter4(5, 5, 5, 5);
        n_vec++;
        if (unlock !== 1'b1) begin n_err++; $display("FAIL default_restored got=%b want=1", unlock); end
        step(1'b0, 0, 1'b1);
    endtask

    task automatic test_random();
        bit kv, lr, pr, rn;
        int k;
        logic [9:0] exp_v, got_v;
        for (int c = 0; c < 1500; c++) begin
            kv = ($urandom_range(0, 1) == 1);
            lr = ($urandom_range(0, 15) == 0);
            pr = ($urandom_range(0, 7) == 0);
            rn = ($urandom_range(0, 299) != 0);
            if (m_ent.size() < CODE_LEN && $urandom_range(0, 3) != 0) k = m_code[m_ent.size()];
            else k = $urandom_range(0, 15);
            if ($urandom_range(0, 9) == 0) repeat ($urandom_range(5, TIMEOUT + 2)) step(1'b0, 0);
            step(kv, k, lr, pr, rn);
            exp_v = {(m_mode == M_OPEN || m_mode == M_PROG), m_err, (m_mode == M_LOCK),
                     (m_mode == M_LOCK), m_done, 3'(m_ent.size()), 2'(m_fail)};
            got_v = {unlock, err_pulse, buzz, locked_out, prog_done, digit_cnt, fail_cnt};
            n_vec++;
            if (got_v !== exp_v) begin
                n_err++; $display("FAIL random_cycle_%0d got=%b want=%b", c, got_v, exp_v);
            end
        end
    endtask

    initial begin
        m_mode = M_ENTRY; m_fail = 0; m_idle = 0; m_lock_left = 0;
        for (int i = 0; i < CODE_LEN; i++) m_code[i] = 5;
        #2;
        test_reset();
        test_unlock();
        test_lockout();
        test_timeout();
        test_program();
        test_back_to_back_req();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
